// File: rtl/addernet_psum_acc_if.sv
// Bundles the partial-sum accumulator's control, data and output handshake signals.
// The master side drives start, tiles and ready. The slave side returns busy, valid, sum and overrun.
// Widths follow the accumulator parameters: NTILE for the count, NACC for the sum, NRESULT+1 for the tile result.
interface addernet_psum_acc_if #(
  parameter int NRESULT = 22,
  parameter int NACC    = 32,
  parameter int NTILE   = 8
);
  logic                      i_start;
  logic [NTILE-1:0]          i_ntile;
  logic signed [NACC-1:0]    i_bias;
  logic                      i_valid;
  logic signed [NRESULT:0]   i_result;
  logic                      o_busy;
  logic                      o_valid;
  logic                      i_ready;
  logic signed [NACC-1:0]    o_sum;
  logic                      o_overrun;

  modport master (
    output i_start, i_ntile, i_bias, i_valid, i_result, i_ready,
    input  o_busy, o_valid, o_sum, o_overrun
  );

  modport slave (
    input  i_start, i_ntile, i_bias, i_valid, i_result, i_ready,
    output o_busy, o_valid, o_sum, o_overrun
  );
endinterface

// File: rtl/addernet_psum_acc.sv
// Accumulates ntile signed core results and emits a saturated bias - sum(results).
// Latency: o_valid and o_sum appear 1 cycle after the last tile is accepted.
// Backpressure: o_sum and o_valid are held until i_ready; i_result is never stalled, and stray i_valid raises o_overrun.
module addernet_psum_acc #(
  parameter int NRESULT = 22,
  parameter int NACC    = 32,
  parameter int NTILE   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  addernet_psum_acc_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic signed [NACC-1:0] SUM_MAX = {1'b0, {(NACC-1){1'b1}}};
  localparam logic signed [NACC-1:0] SUM_MIN = {1'b1, {(NACC-1){1'b0}}};

  state_t                 state_q, state_d;
  logic signed [NACC-1:0] acc_q, acc_d;
  logic [NTILE-1:0]       cnt_q, cnt_d;
  logic [NTILE-1:0]       ntile_q, ntile_d;
  logic signed [NACC-1:0] bias_q, bias_d;
  logic signed [NACC-1:0] sum_q, sum_d;
  logic                   overrun_q, overrun_d;

  logic signed [NACC-1:0] res_ext;
  logic signed [NACC-1:0] acc_nxt;
  logic signed [NACC:0]   diff;
  logic signed [NACC-1:0] diff_sat;

  // Next-state logic: start acceptance, tile accumulation, output hold and overrun tracking
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ntile_d   = ntile_q;
    bias_d    = bias_q;
    sum_d     = sum_q;
    overrun_d = overrun_q;

    res_ext  = {{(NACC-NRESULT-1){bus.i_result[NRESULT]}}, bus.i_result};
    acc_nxt  = acc_q + res_ext;
    // One extra bit makes bias - acc exact, so saturation only needs a top-two-bit check.
    diff     = {bias_q[NACC-1], bias_q} - {acc_nxt[NACC-1], acc_nxt};
    diff_sat = diff[NACC-1:0];
    if (diff[NACC] != diff[NACC-1]) begin
      diff_sat = diff[NACC] ? SUM_MIN : SUM_MAX;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start && (bus.i_ntile != '0)) begin
          // The start clear wins over a same-cycle stray i_valid.
          ntile_d   = bus.i_ntile;
          bias_d    = bus.i_bias;
          acc_d     = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = ST_ACC;
        end else if (bus.i_valid) begin
          overrun_d = 1'b1;
        end
      end
      ST_ACC: begin
        if (bus.i_valid) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + NTILE'(1);
          if (cnt_q == ntile_q - NTILE'(1)) begin
            sum_d   = diff_sat;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.i_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ntile_q   <= '0;
      bias_q    <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ntile_q   <= ntile_d;
      bias_q    <= bias_d;
      sum_q     <= sum_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_valid   = (state_q == ST_DONE);
  assign bus.o_sum     = sum_q;
  assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_addernet_psum_acc.sv
// Bench for the partial-sum accumulator: table-driven runs plus hand-written corner sequences.
// Expected sums are queued at start and compared when the output handshake fires.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
module tb_addernet_psum_acc;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  addernet_psum_acc_if #(.NRESULT(22), .NACC(32), .NTILE(8)) bus ();

  addernet_psum_acc #(.NRESULT(22), .NACC(32), .NTILE(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int                 ntile;
    logic signed [31:0] bias;
    int                 r0;
    int                 step;
    int                 gap;
    int                 rdy;
    logic signed [31:0] exp;
    bit                 ovr;
  } vec_t;

  int                 nchk = 0;
  int                 nerr = 0;
  logic signed [31:0] sb[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endfunction

  // Scoreboard: each completed output handshake pops one expected sum.
  always @(negedge CLK) begin
    if (!RST && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL sb_unexpected: got output %0d, expected no output", bus.o_sum);
      end else begin
        chk("sb_sum", bus.o_sum, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bus.i_ready = (v.rdy == 0);
    if (v.ovr) begin
      bus.i_valid  = 1'b1;
      bus.i_result = 23'sd50;
      tick();
      chk("overrun_set_idle", 32'(bus.o_overrun), 32'd1);
    end
    bus.i_start = 1'b1;
    bus.i_ntile = 8'(v.ntile);
    bus.i_bias  = v.bias;
    tick();
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    sb.push_back(v.exp);
    chk("busy_after_start", 32'(bus.o_busy), 32'd1);
    chk("overrun_clear_on_start", 32'(bus.o_overrun), 32'd0);
    for (int k = 0; k < v.ntile; k++) begin
      bus.i_valid  = 1'b1;
      bus.i_result = 23'(v.r0 + k * v.step);
      tick();
      bus.i_valid = 1'b0;
      if (k < v.ntile - 1) begin
        for (int g = 0; g < v.gap; g++) tick();
      end
    end
    chk("valid_latency", 32'(bus.o_valid), 32'd1);
    for (int i = 0; i < v.rdy; i++) begin
      tick();
      chk("hold_valid", 32'(bus.o_valid), 32'd1);
      chk("hold_sum", bus.o_sum, v.exp);
    end
    bus.i_ready = 1'b1;
    tick();
    chk("idle_valid_after_hs", 32'(bus.o_valid), 32'd0);
    chk("idle_busy_after_hs", 32'(bus.o_busy), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2,   32'sd0,           9,         14, 0, 0, -32'sd32,        1'b0};
    vecs[1] = '{3,   32'sd100,         10,        10, 2, 5, 32'sd40,         1'b0};
    vecs[2] = '{255, 32'sh8000_0000,   4194303,   0,  0, 0, 32'sh8000_0000,  1'b0};
    vecs[3] = '{1,   -32'sd5,          -3,        0,  0, 0, -32'sd2,         1'b0};
    vecs[4] = '{4,   32'sh7fff_ffff,   -4194304,  0,  1, 1, 32'sh7fff_ffff,  1'b0};
    vecs[5] = '{5,   32'sd7,           -8,        3,  0, 0, 32'sd17,         1'b0};
    vecs[6] = '{1,   32'sd0,           7,         0,  0, 0, -32'sd7,         1'b1};

    RST          = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_ntile  = '0;
    bus.i_bias   = '0;
    bus.i_valid  = 1'b0;
    bus.i_result = '0;
    bus.i_ready  = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_sum", bus.o_sum, 32'd0);
    chk("rst_overrun", 32'(bus.o_overrun), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Zero-tile start is ignored; restart mid-ACC and start during the DONE handshake are ignored.
    bus.i_start = 1'b1;
    bus.i_ntile = 8'd0;
    bus.i_bias  = 32'sd55;
    tick();
    bus.i_start = 1'b0;
    chk("zero_ntile_busy", 32'(bus.o_busy), 32'd0);
    bus.i_start = 1'b1;
    bus.i_ntile = 8'd2;
    bus.i_bias  = 32'sd0;
    tick();
    sb.push_back(-32'sd10);
    bus.i_ntile = 8'd5;
    bus.i_bias  = 32'sd999;
    tick();
    bus.i_start = 1'b0;
    chk("restart_ignored_busy", 32'(bus.o_busy), 32'd1);
    bus.i_valid  = 1'b1;
    bus.i_result = 23'sd4;
    tick();
    bus.i_result = 23'sd6;
    tick();
    bus.i_valid = 1'b0;
    chk("restart_done_valid", 32'(bus.o_valid), 32'd1);
    chk("restart_sum", bus.o_sum, -32'sd10);
    bus.i_start = 1'b1;
    bus.i_ntile = 8'd1;
    bus.i_bias  = 32'sd0;
    tick();
    bus.i_start = 1'b0;
    chk("start_in_done_busy", 32'(bus.o_busy), 32'd0);
    chk("start_in_done_valid", 32'(bus.o_valid), 32'd0);

    // Reset after one of three tiles; the next run must show no residue.
    bus.i_start = 1'b1;
    bus.i_ntile = 8'd3;
    bus.i_bias  = 32'sd0;
    tick();
    bus.i_start  = 1'b0;
    bus.i_valid  = 1'b1;
    bus.i_result = 23'sd100;
    tick();
    bus.i_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    chk("midrst_sum", bus.o_sum, 32'd0);
    chk("midrst_overrun", 32'(bus.o_overrun), 32'd0);
    run_vec('{1, 32'sd0, 5, 0, 0, 0, -32'sd5, 1'b0});

    repeat (2) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
